branch_resolve_ctrl: RTL
========================

Name: branch_resolve_ctrl

Overview:
- Sequencing controller for the ID-stage branch equality comparator in the 5-stage MIPS pipeline.
- Detects data hazards on the branch source registers and stalls IF/ID until both operands are valid.
- Drives the comparator's operand forwarding muxes and issues the taken decision plus the IF flush for BEQ/BNE.
- Sits between the hazard unit and the comparator; the PC-source mux consumes its outputs.

Parameters:
- REG_AW, 5, register-index width.
- CNT_W, 16, statistics counter width (used only with BRANCH_STATS_EN).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- beq_id  in  1  BEQ decoded in ID.
- bne_id  in  1  BNE decoded in ID.
- rs_id, rt_id  in  REG_AW  branch source registers.
- ex_regwrite, ex_memread  in  1  EX-stage control.
- ex_rd  in  REG_AW  EX destination.
- mem_regwrite, mem_memread  in  1  MEM-stage control.
- mem_rd  in  REG_AW  MEM destination.
- wb_regwrite  in  1  WB write enable.
- wb_rd  in  REG_AW  WB destination.
- cmp_eq  in  1  comparator result (forwarded A == forwarded B).
- fwd_a_sel, fwd_b_sel  out  2  00 regfile, 01 MEM ALU result, 10 WB result, 11 unused.
- stall  out  1  hold PC and IF/ID, inject bubble into ID/EX.
- branch_taken  out  1  select branch target PC.
- flush_if  out  1  zero the IF/ID instruction.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high. On reset: state=IDLE, cnt=0; all outputs 0 immediately and combinationally, not waiting for a clock edge.
- br = beq_id | bne_id. If both are high, treat as BEQ.
- match(r, x) = (x != 0) & (x == rs_id | x == rt_id). Register 0 never causes a hazard.
- Hazard classes:
  - need2 = ex_memread & match(ex_rd).
  - need1 = !need2 & ((ex_regwrite & match(ex_rd)) | (mem_memread & match(mem_rd))).
- State IDLE:
  - br & need2 -> stall=1, load cnt=1, go WAIT.
  - br & need1 -> stall=1, load cnt=0, go WAIT.
  - br with no hazard -> resolve this cycle (see RESOLVE outputs), stay IDLE.
  - !br -> all outputs 0.
- State WAIT:
  - stall=1, branch_taken=0, flush_if=0.
  - cnt>0 -> decrement cnt.
  - cnt==0 -> go RESOLVE.
  - br deasserted (external flush) -> go IDLE, stall drops next cycle.
- State RESOLVE (and the no-hazard IDLE case):
  - stall=0.
  - branch_taken = beq_id ? cmp_eq : !cmp_eq.
  - flush_if = branch_taken.
  - Next state IDLE.
- Forwarding, valid whenever br=1 and stall=0, computed per operand (rs -> A, rt -> B):
  - 01 if mem_regwrite & !mem_memread & mem_rd == reg & reg != 0.
  - Else 10 if wb_regwrite & wb_rd == reg & reg != 0.
  - Else 00.
  - MEM takes priority over WB.
- While stall=1: fwd selects are 00, with the comparator output ignored.
- Latency:
  - No hazard: decision in the same cycle as ID.
  - ALU producer in EX: 1 stall.
  - Load in EX: 2 stalls.
  - Load in MEM: 1 stall.
- Back-to-back branches: a branch in ID the cycle after RESOLVE is evaluated fresh from IDLE.
- Reset asserted in WAIT: stall deasserts asynchronously; the pending branch is abandoned.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: adds outputs stat_taken, stat_not_taken, stat_stall_cyc, each CNT_W wide.
  - stat_taken and stat_not_taken increment once per resolved branch.
  - stat_stall_cyc increments each cycle stall=1.
  - All saturate at all-ones and reset to 0.
- Undefined: these ports and their counters do not exist; core behaviour is identical.

Test Plan:
- beq_id=1, rs=3, rt=4, no writers, cmp_eq=1 -> same cycle: branch_taken=1, flush_if=1, stall=0, fwd 00/00.
- bne_id=1, rs=5, ex_regwrite=1, ex_rd=5, then the producer advances to MEM, cmp_eq=0 -> stall=1 for 1 cycle; next cycle fwd_a_sel=01, branch_taken=1.
- beq_id=1, rt=7, ex_memread=1, ex_rd=7 -> stall=1 for 2 cycles; then fwd_b_sel=10 with wb_rd=7, branch_taken=cmp_eq.
- beq_id=1, rs=0, ex_regwrite=1, ex_rd=0 -> no stall; fwd_a_sel=00.
- Load hazard entering WAIT, reset pulsed after cycle 1 -> stall=0 asynchronously; state IDLE, no branch_taken pulse.
- With BRANCH_STATS_EN: 3 taken + 2 not-taken branches, one of which has a 2-cycle load stall -> stat_taken=3, stat_not_taken=2, stat_stall_cyc=2.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve sequencer for the ID-stage equality comparator: stalls on
// operand hazards, steers forwarding, issues taken/flush. Optional BRANCH_STATS_EN.
module branch_resolve_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              beq_id,
  input  logic              bne_id,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_regwrite,
  input  logic              mem_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              cmp_eq,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic              branch_taken,
  output logic              flush_if
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_taken,
  output logic [CNT_W-1:0]  stat_not_taken,
  output logic [CNT_W-1:0]  stat_stall_cyc
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, RESOLVE} state_t;

  state_t state, state_nxt;
  logic   br, hit_ex, hit_mem, need2, need1, resolve;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] r,
    input logic              mrw,
    input logic              mmr,
    input logic [REG_AW-1:0] mrd,
    input logic              wrw,
    input logic [REG_AW-1:0] wrd
  );
    if (r == '0)                     return 2'b00;
    if (mrw && !mmr && (mrd == r))   return 2'b01;
    if (wrw && (wrd == r))           return 2'b10;
    return 2'b00;
  endfunction

  assign br      = beq_id | bne_id;
  assign hit_ex  = (ex_rd  != '0) && ((ex_rd  == rs_id) || (ex_rd  == rt_id));
  assign hit_mem = (mem_rd != '0) && ((mem_rd == rs_id) || (mem_rd == rt_id));
  assign need2   = ex_memread & hit_ex;
  assign need1   = !need2 & ((ex_regwrite & hit_ex) | (mem_memread & hit_mem));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The detection cycle in IDLE is itself the first stall; a load in EX
  // needs exactly one more, which is the WAIT state.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    resolve   = 1'b0;
    case (state)
      IDLE: begin
        if (br) begin
          if (need2) begin
            stall     = 1'b1;
            state_nxt = WAIT;
          end else if (need1) begin
            stall     = 1'b1;
            state_nxt = RESOLVE;
          end else begin
            resolve   = 1'b1;
          end
        end
      end
      WAIT: begin
        stall     = 1'b1;
        state_nxt = br ? RESOLVE : IDLE;
      end
      RESOLVE: begin
        resolve   = br;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      stall   = 1'b0;
      resolve = 1'b0;
    end
  end

  // BEQ wins when both decode bits are set.
  assign branch_taken = resolve & (beq_id ? cmp_eq : !cmp_eq);
  assign flush_if     = branch_taken;
  assign fwd_a_sel    = resolve ? fwd_sel(rs_id, mem_regwrite, mem_memread, mem_rd,
                                          wb_regwrite, wb_rd) : 2'b00;
  assign fwd_b_sel    = resolve ? fwd_sel(rt_id, mem_regwrite, mem_memread, mem_rd,
                                          wb_regwrite, wb_rd) : 2'b00;

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_taken     <= '0;
      stat_not_taken <= '0;
      stat_stall_cyc <= '0;
    end else begin
      if (resolve && branch_taken && (stat_taken != '1))
        stat_taken <= stat_taken + CNT_W'(1);
      if (resolve && !branch_taken && (stat_not_taken != '1))
        stat_not_taken <= stat_not_taken + CNT_W'(1);
      if (stall && (stat_stall_cyc != '1))
        stat_stall_cyc <= stat_stall_cyc + CNT_W'(1);
    end
  end
`endif

endmodule
